// File: rtl/jtdsp16_seq.sv
// jtdsp16_seq: DSP16 program sequencer with return stack, interrupts and do/redo loops.
module jtdsp16_seq #(
  parameter int AW        = 16,
  parameter int STK_DEPTH = 4,
  parameter int IRQ_VEC   = 0,
  parameter int ICALL_VEC = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          goto_ja,
  input  logic          call_ja,
  input  logic          goto_b,
  input  logic          icall,
  input  logic          cond_en,
  input  logic          con_result,
  input  logic          pc_halt,
  input  logic [11:0]   i_field,
  input  logic          do_start,
  input  logic          redo,
  input  logic          pt_we,
  input  logic          i_we,
  input  logic          post_inc,
  input  logic [15:0]   data_in,
  input  logic          ext_irq,
  input  logic          clr_flags,
  output logic [AW-1:0] rom_addr,
  output logic [AW-1:0] pt_out,
  output logic          in_irq,
  output logic          do_active,
  output logic          stk_ovf,
  output logic          stk_unf
);
  localparam int SW = $clog2(STK_DEPTH);

  logic [AW-1:0] pc, pt, pi, loop_start, loop_end;
  logic [11:0]   i;
  logic [6:0]    cnt;
  logic [AW-1:0] stk [STK_DEPTH];
  logic [SW-1:0] wp, top;
  logic [SW:0]   depth;
  logic [AW-1:0] pc_nx, pi_nx, ls_nx, le_nx, pc_inc, dir, pop_val;
  logic [6:0]    cnt_nx;
  logic          in_irq_nx, act_nx, push, pop, taken, irq_go, br, full, do_ok, redo_ok;
  logic [2:0]    kind;

  assign rom_addr = pc;
  assign pt_out   = pt;
  assign pc_inc   = pc + 1'b1;
  assign dir      = {pc[AW-1:12], i_field};
  assign kind     = i_field[10:8];
  assign taken    = !cond_en | con_result;
  assign irq_go   = ext_irq & !in_irq & !do_active & !pc_halt;
  assign br       = taken & (goto_ja | call_ja | (goto_b & !kind[2]));
  assign do_ok    = do_start & |i_field[10:7] & |i_field[6:0] & !pc_halt;
  assign redo_ok  = redo & |i_field[6:0] & !pc_halt;
  assign top      = wp - 1'b1;
  assign full     = depth == (SW+1)'(STK_DEPTH);
  assign pop_val  = depth == '0 ? '0 : stk[top];

  always_comb begin
    pc_nx     = pc_halt ? pc : pc_inc;
    pi_nx     = pi;
    in_irq_nx = in_irq;
    act_nx    = do_active;
    ls_nx     = loop_start;
    le_nx     = loop_end;
    cnt_nx    = cnt;
    push      = 1'b0;
    pop       = 1'b0;
    if (irq_go) begin
      pi_nx     = pc;
      pc_nx     = AW'(IRQ_VEC);
      in_irq_nx = 1'b1;
    end else if (icall) begin
      pi_nx     = pc_inc;
      pc_nx     = AW'(ICALL_VEC);
      in_irq_nx = 1'b1;
    end else if (br) begin
      act_nx = 1'b0;
      if (goto_ja | call_ja) begin
        pc_nx = dir;
        push  = !goto_ja;
      end else begin
        pc_nx     = kind[1] ? pt : kind[0] ? pi : pop_val;
        push      = kind[1] & kind[0];
        pop       = kind == 3'd0;
        in_irq_nx = kind == 3'd1 ? 1'b0 : in_irq;
      end
    end else if (do_ok) begin
      ls_nx  = pc_inc;
      le_nx  = pc + AW'(i_field[10:7]);
      cnt_nx = i_field[6:0];
      act_nx = 1'b1;
    end else if (redo_ok) begin
      pc_nx  = loop_start;
      cnt_nx = i_field[6:0];
      act_nx = 1'b1;
    end else if (do_active & !pc_halt & pc == loop_end) begin
      pc_nx  = cnt > 7'd1 ? loop_start : pc_inc;
      cnt_nx = cnt > 7'd1 ? cnt - 7'd1 : cnt;
      act_nx = cnt > 7'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= '0;
      pt         <= '0;
      i          <= '0;
      pi         <= '0;
      loop_start <= '0;
      loop_end   <= '0;
      cnt        <= '0;
      in_irq     <= 1'b0;
      do_active  <= 1'b0;
      wp         <= '0;
      depth      <= '0;
      stk_ovf    <= 1'b0;
      stk_unf    <= 1'b0;
      for (int k = 0; k < STK_DEPTH; k++) stk[k] <= '0;
    end else if (cen) begin
      pc         <= pc_nx;
      pi         <= pi_nx;
      in_irq     <= in_irq_nx;
      do_active  <= act_nx;
      loop_start <= ls_nx;
      loop_end   <= le_nx;
      cnt        <= cnt_nx;
      pt         <= pt_we ? AW'(data_in) : post_inc ? pt + {{(AW-12){i[11]}}, i} : pt;
      i          <= i_we ? data_in[11:0] : i;
      stk_ovf    <= (stk_ovf & !clr_flags) | (push & full);
      stk_unf    <= (stk_unf & !clr_flags) | (pop & depth == '0);
      // A push onto a full stack overwrites the oldest slot, which is where wp points
      if (push) begin
        stk[wp] <= pc_inc;
        wp      <= wp + 1'b1;
        depth   <= full ? depth : depth + 1'b1;
      end else if (pop && depth != '0) begin
        wp    <= top;
        depth <= depth - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_jtdsp16_seq.sv
// tb_jtdsp16_seq: directed checks of the DSP16 sequencer (jumps, stack, loops, IRQs, pt/i).
module tb_jtdsp16_seq;
  logic        clk = 1'b0, rst_n = 1'b0, cen = 1'b1;
  logic        goto_ja, call_ja, goto_b, icall, cond_en, con_result, pc_halt;
  logic [11:0] i_field;
  logic        do_start, redo, pt_we, i_we, post_inc, ext_irq, clr_flags;
  logic [15:0] data_in;
  logic [15:0] rom_addr, pt_out;
  logic        in_irq, do_active, stk_ovf, stk_unf;
  int          total = 0, passed = 0;

  jtdsp16_seq dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .goto_ja(goto_ja), .call_ja(call_ja),
    .goto_b(goto_b), .icall(icall), .cond_en(cond_en), .con_result(con_result),
    .pc_halt(pc_halt), .i_field(i_field), .do_start(do_start), .redo(redo),
    .pt_we(pt_we), .i_we(i_we), .post_inc(post_inc), .data_in(data_in),
    .ext_irq(ext_irq), .clr_flags(clr_flags), .rom_addr(rom_addr), .pt_out(pt_out),
    .in_irq(in_irq), .do_active(do_active), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  always #5 clk = ~clk;

  task automatic idle();
    {goto_ja, call_ja, goto_b, icall, cond_en, con_result, pc_halt} = '0;
    {do_start, redo, pt_we, i_we, post_inc, ext_irq, clr_flags} = '0;
    i_field = '0;
    data_in = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step_pc(input string tag, input logic [15:0] exp);
    tick();
    chk(tag, 32'(rom_addr), 32'(exp));
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", 32'(rom_addr), 0);
    chk("rst_flags", {pt_out, in_irq, do_active, stk_ovf, stk_unf}, 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) step_pc("inc", 16'(k));
    cen = 1'b0; step_pc("cen_hold", 16'h005); cen = 1'b1;
    pc_halt = 1'b1; step_pc("halt", 16'h005);
    // Nested calls and returns
    goto_ja = 1; i_field = 12'h010; step_pc("goto", 16'h010);
    call_ja = 1; i_field = 12'h200; step_pc("call1", 16'h200);
    call_ja = 1; i_field = 12'h300; step_pc("call2", 16'h300);
    goto_b = 1; i_field = 12'h000; step_pc("ret1", 16'h201);
    goto_b = 1; i_field = 12'h000; step_pc("ret2", 16'h011);
    chk("unf_clear", 32'(stk_unf), 0);
    // Overflow: five calls into a four-deep stack drop return address 0x012
    call_ja = 1; i_field = 12'h400; step_pc("c1", 16'h400);
    call_ja = 1; i_field = 12'h500; step_pc("c2", 16'h500);
    call_ja = 1; i_field = 12'h600; step_pc("c3", 16'h600);
    call_ja = 1; i_field = 12'h700; step_pc("c4", 16'h700);
    chk("no_ovf_yet", 32'(stk_ovf), 0);
    call_ja = 1; i_field = 12'h800; step_pc("c5", 16'h800);
    chk("ovf", 32'(stk_ovf), 1);
    goto_b = 1; step_pc("r1", 16'h701);
    goto_b = 1; step_pc("r2", 16'h601);
    goto_b = 1; step_pc("r3", 16'h501);
    goto_b = 1; step_pc("r4", 16'h401);
    chk("no_unf_yet", 32'(stk_unf), 0);
    goto_b = 1; step_pc("r5_empty", 16'h000);
    chk("unf", 32'(stk_unf), 1);
    clr_flags = 1; step_pc("clr", 16'h001);
    chk("flags_cleared", {stk_ovf, stk_unf}, 0);
    // do K=2 N=3 at 0x020, then redo N=2 at 0x023
    goto_ja = 1; i_field = 12'h020; step_pc("to_do", 16'h020);
    do_start = 1; i_field = 12'h103; step_pc("do", 16'h021);
    chk("do_act", 32'(do_active), 1);
    step_pc("l1", 16'h022); step_pc("l2", 16'h021); step_pc("l3", 16'h022);
    step_pc("l4", 16'h021); step_pc("l5", 16'h022);
    chk("act_last", 32'(do_active), 1);
    step_pc("l_exit", 16'h023);
    chk("act_fall", 32'(do_active), 0);
    redo = 1; i_field = 12'h002; step_pc("redo", 16'h021);
    step_pc("rl1", 16'h022); step_pc("rl2", 16'h021); step_pc("rl3", 16'h022);
    step_pc("rl_exit", 16'h023);
    chk("redo_done", 32'(do_active), 0);
    // Interrupt entry and return
    goto_ja = 1; i_field = 12'h040; step_pc("to_irq", 16'h040);
    ext_irq = 1; step_pc("irq", 16'h000);
    chk("in_irq", 32'(in_irq), 1);
    step_pc("isr", 16'h001);
    goto_b = 1; i_field = 12'h100; step_pc("iret", 16'h040);
    chk("iret_clr", 32'(in_irq), 0);
    // IRQ deferred by an active loop (K=1 N=2 at 0x050)
    goto_ja = 1; i_field = 12'h050; step_pc("to_loop", 16'h050);
    do_start = 1; i_field = 12'h082; step_pc("do2", 16'h051);
    ext_irq = 1; step_pc("defer1", 16'h051);
    chk("defer_irq1", {in_irq, do_active}, 2'b01);
    ext_irq = 1; step_pc("defer2", 16'h052);
    chk("defer_irq2", {in_irq, do_active}, 2'b00);
    ext_irq = 1; step_pc("late_irq", 16'h000);
    chk("late_in_irq", 32'(in_irq), 1);
    goto_b = 1; i_field = 12'h100; step_pc("iret2", 16'h052);
    // Conditional branches, pt/i registers, goto pt
    goto_ja = 1; cond_en = 1; i_field = 12'h123; step_pc("cond_no", 16'h053);
    goto_ja = 1; cond_en = 1; con_result = 1; i_field = 12'h030; step_pc("cond_yes", 16'h030);
    i_we = 1; data_in = 16'h0FFF; tick();
    pt_we = 1; data_in = 16'h0100; tick();
    chk("pt_load", 32'(pt_out), 32'h0100);
    post_inc = 1; tick();
    post_inc = 1; tick();
    chk("pt_postinc", 32'(pt_out), 32'h00FE);
    goto_b = 1; i_field = 12'h200; step_pc("goto_pt", 16'h00FE);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/jtdsp16_seq.md
Name: jtdsp16_seq

Overview:
- Parametrised program sequencer (XAAU successor) for the DSP16 core.
- Generates the ROM fetch address and handles these events:
  - direct and pointer jumps
  - a return-address stack of configurable depth
  - interrupt entry and return
  - hardware do/redo loops
- Sits between the instruction decoder and the program ROM.
- Replaces the single-register return scheme with a stack and adds zero-overhead looping.

Parameters:
AW, 16, program address width (must be ≥ 12).
STK_DEPTH, 4, return-stack entries (power of 2, ≥ 2).
IRQ_VEC, 0, address loaded on interrupt entry.
ICALL_VEC, 1, address loaded on icall.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cen  in  1  clock enable; all state updates only when high
goto_ja  in  1  direct jump
call_ja  in  1  direct call
goto_b  in  1  pointer-class branch; kind in i_field[10:8]: 0 ret, 1 iret, 2 goto pt, 3 call pt
icall  in  1  software interrupt call
cond_en  in  1  branch is conditional
con_result  in  1  condition outcome
pc_halt  in  1  hold pc
i_field  in  12  instruction field
do_start  in  1  do: K=i_field[10:7], N=i_field[6:0]
redo  in  1  redo: N=i_field[6:0]
pt_we  in  1  load pt from data_in
i_we  in  1  load i from data_in[11:0]
post_inc  in  1  pt <= pt + sext(i)
data_in  in  16  register load data
ext_irq  in  1  interrupt request (level)
clr_flags  in  1  clear sticky error flags
rom_addr  out  AW  fetch address (= pc)
pt_out  out  AW  table pointer
in_irq  out  1  inside interrupt service
do_active  out  1  loop running
stk_ovf  out  1  sticky push-while-full
stk_unf  out  1  sticky pop-while-empty

Behaviour:
Reset (rst_n low, asynchronous):
- pc, pt, i, pi, loop registers and all stack entries clear to 0.
- Stack becomes empty; every output reads 0.

Branches:
- taken = !cond_en | con_result; an untaken branch behaves as a plain increment.
- All arithmetic is modulo 2^AW.
- Direct target = {pc[AW-1:12], i_field}.
- sext(i) sign-extends the 12-bit i register to AW bits.

Next-pc priority, evaluated per cen cycle, highest first:
1. IRQ entry, when ext_irq & !in_irq & !do_active & !pc_halt:
   - pi <= pc (the interrupted instruction is re-fetched on return).
   - pc <= IRQ_VEC; in_irq <= 1.
   - Decoder strobes in the same cycle are ignored.
2. icall: pi <= pc+1, pc <= ICALL_VEC, in_irq <= 1.
3. Taken branch:
   - goto_ja / call_ja -> direct target.
   - goto pt / call pt -> pt.
   - ret -> pop.
   - iret -> pc <= pi, in_irq <= 0.
   - Calls push pc+1.
   - Any taken branch while do_active clears do_active (loop aborted).
4. Loop end, when do_active & pc==loop_end:
   - cnt>1: pc <= loop_start, cnt <= cnt-1.
   - cnt==1: do_active <= 0, pc <= pc+1.
5. pc_halt: pc unchanged. Loop and IRQ logic are also frozen.
6. Default: pc <= pc+1.

Do / redo:
- do_start with K≥1 and N≥1:
  - loop_start <= pc+1, loop_end <= pc+K, cnt <= N.
  - do_active <= 1; pc <= pc+1.
- K==0 or N==0: the do executes as a no-op.
- redo with N≥1:
  - pc <= loop_start, cnt <= N, do_active <= 1.
  - loop_start and loop_end are unchanged from the last do.
- redo N==0: no-op.
- do_start or redo while do_active restarts the loop with the new values.
- A branch, do_start or redo on the loop_end instruction takes precedence over the wrap.

Return stack (LIFO, STK_DEPTH entries):
- Push when full: the oldest entry is discarded (circular) and stk_ovf <= 1.
- Pop when empty: returns 0 and stk_unf <= 1.
- Push and pop never coincide (only one branch per instruction).

Register updates (independent of the pc selection):
- pt: pt_we has priority over post_inc. pt_we loads data_in[AW-1:0] zero-extended.
- i: i_we loads data_in[11:0].
- clr_flags clears stk_ovf and stk_unf; a set event in the same cycle wins.

Other rules:
- cen low: all state is held, including across a mid-operation reset release.
- rom_addr is combinationally equal to pc; zero additional latency.

Test Plan:
- Reset then 5 cen cycles with no strobes -> rom_addr 0,1,2,3,4,5.
- At pc=0x010: call_ja i_field=0x200; at 0x200: call_ja 0x300; at 0x300: ret; at 0x201: ret -> pc sequence 0x200, 0x300, 0x201, 0x011; stk_unf stays 0.
- STK_DEPTH=4: five nested calls, then five rets -> stk_ovf=1; the fifth ret returns 0 and sets stk_unf=1. Then clr_flags -> both flags 0.
- do at pc=0x020 with K=2, N=3 -> fetch sequence 0x21,0x22,0x21,0x22,0x21,0x22,0x23; do_active falls as pc goes 0x22->0x23. Then redo N=2 -> 0x21,0x22,0x21,0x22, then continue at 0x23.
- ext_irq at pc=0x040 -> pc=IRQ_VEC, in_irq=1. iret -> pc=0x040, in_irq=0. ext_irq held during do_active -> entry deferred until the loop exits.
- cond_en=1, con_result=0 with goto_ja -> pc+1. i_we 0xFFF, pt_we 0x0100, post_inc twice -> pt_out=0x00FE. goto pt -> pc=0x00FE.
